// File: rtl/game_state_fetcher.sv
// game_state_fetcher
// Drives port B of the video data memory once per frame to pick up the five
// game-state words written by the ARMv4 program (lives P1/P2, correct doors,
// positions P1/P2). Each word is first captured into a shadow register; only
// when all five have been read are they copied to the outputs in one edge.
// This means the screen drawer never mixes values from two different scans.
//
// Scan sequence:
//   IDLE   -> wait for a trigger (frame_start, refresh_req or a remembered
//             frame_start) while enable is high
//   READ   -> for each of the five words, present its address, wait
//             READ_LATENCY edges for the memory, then capture data_in
//   COMMIT -> publish all shadows at once, pulse done, back to IDLE
module game_state_fetcher #(
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [31:0] ADDR_P1_LIVES = 32'h0000_6000,
  parameter logic [31:0] ADDR_P2_LIVES = 32'h0000_7000,
  parameter logic [31:0] ADDR_DOORS    = 32'h0000_8000,
  parameter logic [31:0] ADDR_P1_POS   = 32'h0000_9000,
  parameter logic [31:0] ADDR_P2_POS   = 32'h0000_A000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        refresh_req,
  input  logic [31:0] data_in,
  output logic [31:0] vga_addr,
  output logic [1:0]  p1_lives,
  output logic [1:0]  p2_lives,
  output logic [1:0]  correct_door_1,
  output logic [1:0]  correct_door_2,
  output logic [1:0]  player_1_pos,
  output logic [1:0]  player_2_pos,
  output logic        busy,
  output logic        done,
  output logic        snapshot_valid
);

  // The wait counter is 3 bits wide, so latencies of 1..7 edges are supported.
  localparam logic [2:0] LatCount  = 3'(READ_LATENCY);
  localparam logic [2:0] LastField = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  field_q;
  logic [2:0]  waitCnt_q;
  logic        pending_q;
  logic [31:0] vgaAddr_q;

  // Shadow copies filled one field at a time during READ.
  logic [1:0]  shP1Lives_q;
  logic [1:0]  shP2Lives_q;
  logic [1:0]  shDoor1_q;
  logic [1:0]  shDoor2_q;
  logic [1:0]  shP1Pos_q;
  logic [1:0]  shP2Pos_q;

  // Committed, externally visible values.
  logic [1:0]  p1Lives_q;
  logic [1:0]  p2Lives_q;
  logic [1:0]  door1_q;
  logic [1:0]  door2_q;
  logic [1:0]  p1Pos_q;
  logic [1:0]  p2Pos_q;
  logic        busy_q;
  logic        done_q;
  logic        snapshotValid_q;

  logic        trigger_d;
  logic [2:0]  nextField_d;
  logic        unusedDataBits;

  // Only the low nibble of any game-state word carries information.
  assign unusedDataBits = ^data_in[31:4];

  // A scan may start from a new frame, an explicit refresh, or a frame_start
  // that arrived while the previous scan was still running.
  assign trigger_d   = enable & (frame_start | refresh_req | pending_q);
  assign nextField_d = field_q + 3'd1;

  // Word address for each field, in the fixed scan order.
  function automatic logic [31:0] fieldAddr(input logic [2:0] f);
    logic [31:0] a;
    a = ADDR_P1_LIVES;
    case (f)
      3'd0:    a = ADDR_P1_LIVES;
      3'd1:    a = ADDR_P2_LIVES;
      3'd2:    a = ADDR_DOORS;
      3'd3:    a = ADDR_P1_POS;
      3'd4:    a = ADDR_P2_POS;
      default: a = ADDR_P1_LIVES;
    endcase
    return a;
  endfunction

  // Scan sequencer: state, address, shadows, committed outputs and pending flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      field_q         <= 3'd0;
      waitCnt_q       <= 3'd0;
      pending_q       <= 1'b0;
      vgaAddr_q       <= 32'd0;
      shP1Lives_q     <= 2'd0;
      shP2Lives_q     <= 2'd0;
      shDoor1_q       <= 2'd0;
      shDoor2_q       <= 2'd0;
      shP1Pos_q       <= 2'd0;
      shP2Pos_q       <= 2'd0;
      p1Lives_q       <= 2'd0;
      p2Lives_q       <= 2'd0;
      door1_q         <= 2'd0;
      door2_q         <= 2'd0;
      p1Pos_q         <= 2'd0;
      p2Pos_q         <= 2'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      snapshotValid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Remember a frame_start we cannot act on right now (busy or disabled).
      // The IDLE start branch below overrides this when the scan begins.
      if (frame_start) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (trigger_d) begin
            vgaAddr_q <= ADDR_P1_LIVES;
            field_q   <= 3'd0;
            waitCnt_q <= 3'd0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= READ;
          end
        end

        READ: begin
          if (waitCnt_q == LatCount) begin
            case (field_q)
              3'd0: shP1Lives_q <= data_in[1:0];
              3'd1: shP2Lives_q <= data_in[1:0];
              3'd2: begin
                shDoor1_q <= data_in[1:0];
                shDoor2_q <= data_in[3:2];
              end
              3'd3: shP1Pos_q <= data_in[1:0];
              3'd4: shP2Pos_q <= data_in[1:0];
              default: begin
              end
            endcase

            if (field_q == LastField) begin
              state_q <= COMMIT;
            end else begin
              field_q   <= nextField_d;
              vgaAddr_q <= fieldAddr(nextField_d);
              waitCnt_q <= 3'd0;
            end
          end else begin
            waitCnt_q <= waitCnt_q + 3'd1;
          end
        end

        COMMIT: begin
          p1Lives_q       <= shP1Lives_q;
          p2Lives_q       <= shP2Lives_q;
          door1_q         <= shDoor1_q;
          door2_q         <= shDoor2_q;
          p1Pos_q         <= shP1Pos_q;
          p2Pos_q         <= shP2Pos_q;
          done_q          <= 1'b1;
          snapshotValid_q <= 1'b1;
          busy_q          <= 1'b0;
          state_q         <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vga_addr       = vgaAddr_q;
  assign p1_lives       = p1Lives_q;
  assign p2_lives       = p2Lives_q;
  assign correct_door_1 = door1_q;
  assign correct_door_2 = door2_q;
  assign player_1_pos   = p1Pos_q;
  assign player_2_pos   = p2Pos_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign snapshot_valid = snapshotValid_q;

endmodule
